core_cg_enable_ctrl: RTL and testbench



---
 rtl/core_cg_enable_ctrl.sv | 153 +++++++++++++++
 tb/tb_core_cg_enable_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_cg_enable_ctrl.sv
// ---------------------------------------------------------------------------
// core_cg_enable_ctrl
//
// Always-on controller producing the enable for the core clock-gating cell.
// It runs on the ungated clock. The core clock is gated once the core reports
// a sustained sleep-ready condition, and it is re-enabled on a wake event.
// The block also reports sleep status, a wake pulse and the length of the
// current or last sleep episode.
//
// Parameters
//   IDLE_DELAY   cycles gate_ok must persist in IDLE_WAIT before gating (>=1)
//   WAKE_DELAY   cycles the clock stays enabled after wake before re-gating
//                may start (>=1)
//   CNT_W        width of the sleep-duration counter
//
// Ports
//   clk_i          ungated free-running clock
//   rst_ni         asynchronous active-low reset
//   sleep_req_i    core requests sleep (WFI retired, pipeline quiescent)
//   busy_i         outstanding fetch/LSU/bus activity; blocks gating
//   irq_pending_i  pending enabled interrupt
//   debug_req_i    debug halt request
//   scan_cg_en_i   test mode: forces the clock enabled
//   clk_en_o       enable to the core clock gate
//   sleep_o        high while the core clock is gated
//   wake_evt_o     single-cycle pulse on leaving SLEEP
//   sleep_cnt_o    gated cycles in the current/last sleep episode (saturating)
// ---------------------------------------------------------------------------
module core_cg_enable_ctrl #(
    parameter int unsigned IDLE_DELAY = 4,
    parameter int unsigned WAKE_DELAY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sleep_req_i,
    input  logic             busy_i,
    input  logic             irq_pending_i,
    input  logic             debug_req_i,
    input  logic             scan_cg_en_i,
    output logic             clk_en_o,
    output logic             sleep_o,
    output logic             wake_evt_o,
    output logic [CNT_W-1:0] sleep_cnt_o
);

    localparam int unsigned MAX_DELAY = (IDLE_DELAY > WAKE_DELAY) ? IDLE_DELAY : WAKE_DELAY;
    localparam int unsigned DLY_W     = $clog2(MAX_DELAY + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_IDLE_WAIT,
        ST_SLEEP,
        ST_WAKE
    } state_e;

    state_e             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [CNT_W-1:0]   sleep_cnt_q, sleep_cnt_d;
    logic               wake_evt_q, wake_evt_d;
    logic               sleep_q;

    logic gate_ok;
    logic wake;

    assign gate_ok = sleep_req_i & ~busy_i;
    assign wake    = irq_pending_i | debug_req_i;

    // Next-state, delay counter, sleep counter and wake pulse.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        sleep_cnt_d = sleep_cnt_q;
        wake_evt_d  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (gate_ok && !wake) begin
                    state_d = ST_IDLE_WAIT;
                    dly_d   = DLY_W'(IDLE_DELAY - 1);
                end
            end

            ST_IDLE_WAIT: begin
                // Wake takes priority over a still-valid gate request.
                if (!gate_ok || wake) begin
                    state_d = ST_RUN;
                end else if (dly_q == '0) begin
                    state_d     = ST_SLEEP;
                    sleep_cnt_d = '0;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end

            ST_SLEEP: begin
                // The exit cycle is still a gated cycle, so it is counted.
                if (sleep_cnt_q != '1) begin
                    sleep_cnt_d = sleep_cnt_q + CNT_W'(1);
                end
                if (wake || !sleep_req_i) begin
                    state_d    = ST_WAKE;
                    dly_d      = DLY_W'(WAKE_DELAY - 1);
                    wake_evt_d = 1'b1;
                end
            end

            ST_WAKE: begin
                if (dly_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Scan mode overrides everything: return to RUN silently and
        // keep the reported sleep duration untouched.
        if (scan_cg_en_i) begin
            state_d     = ST_RUN;
            wake_evt_d  = 1'b0;
            sleep_cnt_d = sleep_cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            dly_q       <= '0;
            sleep_cnt_q <= '0;
            wake_evt_q  <= 1'b0;
            sleep_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            sleep_cnt_q <= sleep_cnt_d;
            wake_evt_q  <= wake_evt_d;
            sleep_q     <= (state_d == ST_SLEEP);
        end
    end

    // Only the scan term is combinational; the state term changes on clk_i
    // edges or asynchronously on reset.
    assign clk_en_o    = (state_q != ST_SLEEP) | scan_cg_en_i;
    assign sleep_o     = sleep_q;
    assign wake_evt_o  = wake_evt_q;
    assign sleep_cnt_o = sleep_cnt_q;

endmodule

// File: tb/tb_core_cg_enable_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_cg_enable_ctrl
//
// Self-checking bench for core_cg_enable_ctrl (IDLE_DELAY=4, WAKE_DELAY=2,
// CNT_W=4). A behavioural reference model tracks eligibility streaks,
// post-wake hold time and sleep duration with plain integers. Directed
// scenarios also check fixed cycle numbers from the block's timing rules.
// ---------------------------------------------------------------------------
module tb_core_cg_enable_ctrl;

    localparam int unsigned IDLE_DELAY = 4;
    localparam int unsigned WAKE_DELAY = 2;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned CMAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             sleep_req_i;
    logic             busy_i;
    logic             irq_pending_i;
    logic             debug_req_i;
    logic             scan_cg_en_i;
    logic             clk_en_o;
    logic             sleep_o;
    logic             wake_evt_o;
    logic [CNT_W-1:0] sleep_cnt_o;

    logic [CNT_W+2:0] obs;
    assign obs = {clk_en_o, sleep_o, wake_evt_o, sleep_cnt_o};

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state.
    bit          m_sleep;
    bit          m_evt;
    int unsigned m_streak;
    int unsigned m_hold;
    int unsigned m_cnt;

    core_cg_enable_ctrl #(
        .IDLE_DELAY (IDLE_DELAY),
        .WAKE_DELAY (WAKE_DELAY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .sleep_req_i   (sleep_req_i),
        .busy_i        (busy_i),
        .irq_pending_i (irq_pending_i),
        .debug_req_i   (debug_req_i),
        .scan_cg_en_i  (scan_cg_en_i),
        .clk_en_o      (clk_en_o),
        .sleep_o       (sleep_o),
        .wake_evt_o    (wake_evt_o),
        .sleep_cnt_o   (sleep_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_sleep  = 1'b0;
        m_evt    = 1'b0;
        m_streak = 0;
        m_hold   = 0;
        m_cnt    = 0;
    endtask

    // Sleep is entered after IDLE_DELAY+1 consecutive eligible cycles outside
    // sleep and the post-wake hold. The hold lasts WAKE_DELAY cycles.
    task automatic model_step();
        bit ok;
        bit wk;
        ok    = sleep_req_i && !busy_i;
        wk    = irq_pending_i || debug_req_i;
        m_evt = 1'b0;
        if (scan_cg_en_i) begin
            m_sleep  = 1'b0;
            m_hold   = 0;
            m_streak = 0;
        end else if (m_sleep) begin
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (wk || !sleep_req_i) begin
                m_sleep = 1'b0;
                m_hold  = WAKE_DELAY;
                m_evt   = 1'b1;
            end
        end else if (m_hold > 0) begin
            m_hold   = m_hold - 1;
            m_streak = 0;
        end else if (ok && !wk) begin
            m_streak = m_streak + 1;
            if (m_streak == IDLE_DELAY + 1) begin
                m_sleep  = 1'b1;
                m_cnt    = 0;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
    endtask

    function automatic logic [CNT_W+2:0] model_exp();
        logic [CNT_W-1:0] c;
        c = m_cnt[CNT_W-1:0];
        return {(!m_sleep) || scan_cg_en_i, m_sleep, m_evt, c};
    endfunction

    task automatic set_in(input logic sr, input logic bz, input logic irq,
                          input logic dbg, input logic scan);
        sleep_req_i   = sr;
        busy_i        = bz;
        irq_pending_i = irq;
        debug_req_i   = dbg;
        scan_cg_en_i  = scan;
    endtask

    // Advance one clock; afterwards the bench sits 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        model_reset();
        #3;
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, {CNT_W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", obs, {1'b1, 1'b0, 1'b0, {CNT_W{1'b0}}});
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (obs !== {1'b1, 1'b0, 1'b0, {CNT_W{1'b0}}}) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got %b expected %b", c, obs, {1'b1, 1'b0, 1'b0, {CNT_W{1'b0}}});
            end
        end
    endtask

    task automatic test_gate_wake();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            set_in(1, 0, (c == 15), 0, 0);
            tick();
            checks++;
            if (obs !== model_exp()) begin
                errors++;
                $display("FAIL gate_wake model cyc%0d: got %b expected %b", c + 1, obs, model_exp());
            end
            if (c + 1 == 4 || c + 1 == 5) begin
                checks++;
                if (clk_en_o !== (c + 1 == 4) || sleep_o !== (c + 1 == 5)) begin
                    errors++;
                    $display("FAIL gate_latency cyc%0d: got en=%b sleep=%b expected en=%b sleep=%b",
                             c + 1, clk_en_o, sleep_o, (c + 1 == 4), (c + 1 == 5));
                end
            end
            if (c + 1 == 16 || c + 1 == 17) begin
                checks++;
                if (clk_en_o !== 1'b1 || wake_evt_o !== (c + 1 == 16) || sleep_cnt_o !== 4'd11) begin
                    errors++;
                    $display("FAIL wake_latency cyc%0d: got en=%b evt=%b cnt=%0d expected en=1 evt=%b cnt=11",
                             c + 1, clk_en_o, wake_evt_o, sleep_cnt_o, (c + 1 == 16));
                end
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            set_in(1, (c == 3), 0, 0, 0);
            tick();
            checks++;
            if (obs !== model_exp() || clk_en_o !== (c + 1 < 9)) begin
                errors++;
                $display("FAIL abort cyc%0d: got %b expected %b (en=%b)", c + 1, obs, model_exp(), (c + 1 < 9));
            end
        end
    endtask

    task automatic test_simul_wake();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            set_in(1, 0, 0, 1, 0);
            tick();
            checks++;
            if (obs !== model_exp() || clk_en_o !== 1'b1 || sleep_o !== 1'b0) begin
                errors++;
                $display("FAIL simul_wake cyc%0d: got %b expected %b", c + 1, obs, model_exp());
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            set_in(1, 0, (c == 8), 0, 0);
            tick();
            checks++;
            if (obs !== model_exp() ||
                clk_en_o !== !((c + 1 >= 5 && c + 1 <= 8) || c + 1 >= 16)) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %b expected %b", c + 1, obs, model_exp());
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c < 45; c++) begin
            set_in(1, 0, 0, 0, 0);
            tick();
            checks++;
            if (obs !== model_exp()) begin
                errors++;
                $display("FAIL saturation model cyc%0d: got %b expected %b", c + 1, obs, model_exp());
            end
        end
        checks++;
        if (sleep_cnt_o !== 4'd15 || sleep_o !== 1'b1) begin
            errors++;
            $display("FAIL saturation_final: got cnt=%0d sleep=%b expected cnt=15 sleep=1", sleep_cnt_o, sleep_o);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (obs !== model_exp() || sleep_cnt_o !== 4'd15) begin
            errors++;
            $display("FAIL saturation_hold: got %b expected %b", obs, model_exp());
        end
    endtask

    task automatic test_scan_and_reset();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_in(1, 0, 0, 0, 0);
            tick();
        end
        // Now in cycle 8: sleeping with a count of 3.
        set_in(1, 0, 0, 0, 1);
        #1;
        checks++;
        if (clk_en_o !== 1'b1 || sleep_o !== 1'b1 || sleep_cnt_o !== 4'd3) begin
            errors++;
            $display("FAIL scan_immediate: got en=%b sleep=%b cnt=%0d expected en=1 sleep=1 cnt=3",
                     clk_en_o, sleep_o, sleep_cnt_o);
        end
        tick();
        checks++;
        if (obs !== model_exp() || sleep_o !== 1'b0 || wake_evt_o !== 1'b0 || sleep_cnt_o !== 4'd3) begin
            errors++;
            $display("FAIL scan_next: got %b expected %b", obs, model_exp());
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (obs !== model_exp() || wake_evt_o !== 1'b0 || sleep_cnt_o !== 4'd3) begin
            errors++;
            $display("FAIL scan_after: got %b expected %b", obs, model_exp());
        end
        for (int c = 0; c < 8; c++) begin
            set_in(1, 0, 0, 0, 0);
            tick();
        end
        checks++;
        if (obs !== model_exp() || sleep_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_presleep: got %b expected %b", obs, model_exp());
        end
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, {CNT_W{1'b0}}}) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", obs, {1'b1, 1'b0, 1'b0, {CNT_W{1'b0}}});
        end
        set_in(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(99) < 88), ($urandom_range(99) < 8),
                   ($urandom_range(99) < 3), ($urandom_range(99) < 2),
                   ($urandom_range(99) < 2));
            tick();
            checks++;
            if (obs !== model_exp()) begin
                errors++;
                $display("FAIL random cyc%0d: got %b expected %b", c, obs, model_exp());
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_gate_wake();
        test_abort();
        test_simul_wake();
        test_back_to_back();
        test_saturation();
        test_scan_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
